// File: rtl/mpsoc_sysid_arbiter.sv
// rtl/mpsoc_sysid_arbiter.sv - shares the sysid Avalon-MM slave among N masters, one read in flight
// Define SYSID_ARB_FIXED_PRIO_EN for fixed priority (master 0 highest) instead of round-robin.
module mpsoc_sysid_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_MASTERS-1:0]   m_read,
  input  logic [N_MASTERS-1:0]   m_address,
  output logic [N_MASTERS-1:0]   m_waitrequest,
  output logic [32*N_MASTERS-1:0] m_readdata,
  output logic [N_MASTERS-1:0]   m_readdatavalid,
  output logic                   s_address,
  input  logic [31:0]            s_readdata,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] next_grant;
  logic             found;
  logic [31:0]      data_q;

`ifdef SYSID_ARB_FIXED_PRIO_EN
  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!found && m_read[k]) begin
        found      = 1'b1;
        next_grant = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant;
  int               cand;

  // Search starts one past the last completed grant, wrapping at N_MASTERS.
  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    cand       = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = (int'(last_grant) + 1 + k) % N_MASTERS;
      if (!found && m_read[cand]) begin
        found      = 1'b1;
        next_grant = IDX_W'(cand);
      end
    end
  end

  // Only a completed read advances the pointer; aborts leave it untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDX_W'(N_MASTERS - 1);
    end else if (state == ISSUE && m_read[grant]) begin
      last_grant <= grant;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      grant  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= next_grant;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_read[grant]) begin
            data_q <= s_readdata;
            state  <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign s_address = (state == ISSUE) ? m_address[grant] : 1'b0;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
    assign m_waitrequest[i]   = m_read[i] & ~(state == ISSUE && grant == IDX_W'(i));
    assign m_readdatavalid[i] = (state == RESP) && (grant == IDX_W'(i));
    assign m_readdata[32*i +: 32] = m_readdatavalid[i] ? data_q : 32'h0;
  end

endmodule

// File: tb/tb_mpsoc_sysid_arbiter.sv
// tb/tb_mpsoc_sysid_arbiter.sv - scoreboard bench for mpsoc_sysid_arbiter
module tb_mpsoc_sysid_arbiter;

  localparam logic [31:0] SYS = 32'h624E5E3A;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [3:0]   m_read;
  logic [3:0]   m_address;
  logic [3:0]   m_waitrequest;
  logic [127:0] m_readdata;
  logic [3:0]   m_readdatavalid;
  logic         s_address;
  logic [31:0]  s_readdata;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t;

  typedef struct {
    int          m;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t sb[$];

  mpsoc_sysid_arbiter #(.N_MASTERS(4), .IDX_W(2)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .m_read          (m_read),
    .m_address       (m_address),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .s_address       (s_address),
    .s_readdata      (s_readdata),
    .busy            (busy)
  );

  assign s_readdata = s_address ? SYS : 32'h0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int m, input logic [31:0] d, input int c);
    exp_t e;
    e.m = m; e.d = d; e.c = c;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (m_readdatavalid[i]) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: master %0d data %0h at cycle %0d, none expected", i, m_readdata[32*i +: 32], cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("valid_master", 128'(i), 128'(e.m));
            chk("valid_data", 128'(m_readdata[32*i +: 32]), 128'(e.d));
            chk("valid_cycle", 128'(cyc), 128'(e.c));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, got cycle %0d expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; m_read = '0; m_address = '0;
    repeat (3) step();
    @(negedge clock);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(m_readdatavalid), 128'(0));
    chk("rst_readdata", m_readdata, 128'(0));
    chk("rst_s_address", 128'(s_address), 128'(0));
    m_read = 4'b1000;
    #1 chk("rst_waitreq_follows", 128'(m_waitrequest), 128'(4'b1000));
    m_read = '0;
    step();
    reset_n = 1'b1;

    // single read: master 2, address 1
    step();
    t = cyc; m_address = 4'b0100; m_read = 4'b0100; push(2, SYS, t + 2);
    @(negedge clock);
    chk("single_wr_t", 128'(m_waitrequest), 128'(4'b0100));
    chk("single_busy_t", 128'(busy), 128'(0));
    step(); @(negedge clock);
    chk("single_wr_t1", 128'(m_waitrequest), 128'(4'b0000));
    chk("single_busy_t1", 128'(busy), 128'(1));
    chk("single_saddr_t1", 128'(s_address), 128'(1));
    step(); m_read = '0; @(negedge clock);
    chk("single_busy_t2", 128'(busy), 128'(1));
    chk("single_saddr_t2", 128'(s_address), 128'(0));
    step(); @(negedge clock);
    chk("single_busy_t3", 128'(busy), 128'(0));

    // address 0 read from master 0
    step();
    t = cyc; m_address = 4'b0000; m_read = 4'b0001; push(0, 32'h0, t + 2);
    step(); @(negedge clock);
    chk("addr0_saddr", 128'(s_address), 128'(0));
    chk("addr0_wr", 128'(m_waitrequest), 128'(4'b0000));
    step(); m_read = '0;
    repeat (2) step();

    // abort: grant master 1, then withdraw during ISSUE
    t = cyc; m_address = 4'b1010; m_read = 4'b0010;
    step(); m_read = '0; @(negedge clock);
    chk("abort_busy_issue", 128'(busy), 128'(1));
    step(); @(negedge clock);
    chk("abort_back_idle", 128'(busy), 128'(0));
    t = cyc; m_read = 4'b1100;
    push(2, 32'h0, t + 2);
`ifdef SYSID_ARB_FIXED_PRIO_EN
    push(2, 32'h0, t + 5);
`else
    push(3, SYS, t + 5);
`endif
    repeat (6) step();
    m_read = '0;
    repeat (3) step();

    // continuous requests from all masters from reset
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; m_address = 4'b0101; m_read = 4'b1111; t = cyc;
`ifdef SYSID_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 5; k++) push(0, SYS, t + 2 + 3 * k);
`else
    push(0, SYS,   t + 2);
    push(1, 32'h0, t + 5);
    push(2, SYS,   t + 8);
    push(3, 32'h0, t + 11);
    push(0, SYS,   t + 14);
`endif
    repeat (15) step();
    m_read = '0;
    repeat (3) step();

    // reset during RESP
    t = cyc; m_address = 4'b1000; m_read = 4'b1000; push(3, SYS, t + 2);
    step(); step(); m_read = '0;
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(m_readdatavalid), 128'(0));
    chk("midrst_readdata", m_readdata, 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    step();
    reset_n = 1'b1; t = cyc; m_address = 4'b0001; m_read = 4'b1111; push(0, SYS, t + 2);
    step(); step(); m_read = '0;
    repeat (5) step();
    @(negedge clock);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
